// File: rtl/ram_access_sequencer.sv
// Sequences a CPU memory request (byte/halfword/word) onto a byte-wide RAM,
// with programmable wait states, big-endian byte order and an MFA/MOC handshake.
module ram_access_sequencer #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        MFA,
    input  logic        RW,
    input  logic [1:0]  SIZE,
    input  logic [7:0]  ADDR,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        MOC,
    output logic        RAM_EN,
    output logic        RAM_RW,
    output logic [7:0]  RAM_ADDR,
    output logic [7:0]  RAM_WDATA,
    input  logic [7:0]  RAM_RDATA
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [1:0]       byte_idx, byte_idx_d;
    logic [1:0]       byte_last, byte_last_d;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
    logic             rw_q, rw_q_d;
    logic [31:0]      wsh, wsh_d;      // remaining write bytes, next one in [31:24]
    logic [31:0]      rsh, rsh_d;      // read bytes shifted in from the bottom
    logic [31:0]      rsh_next;
    logic [31:0]      din_aligned;
    logic [31:0]      dout_d;
    logic             moc_d, ram_en_d, ram_rw_d;
    logic [7:0]       ram_addr_d, ram_wdata_d;

    // Left-justify the write data so the first byte sent is always in [31:24]
    always_comb begin
        din_aligned = DIN;
        case (SIZE)
            2'b00:   din_aligned = {DIN[7:0], 24'h000000};
            2'b01:   din_aligned = {DIN[15:0], 16'h0000};
            default: din_aligned = DIN;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state;
        byte_idx_d  = byte_idx;
        byte_last_d = byte_last;
        wait_cnt_d  = wait_cnt;
        rw_q_d      = rw_q;
        wsh_d       = wsh;
        rsh_d       = rsh;
        rsh_next    = rw_q ? {rsh[23:0], RAM_RDATA} : rsh;
        dout_d      = DOUT;
        moc_d       = MOC;
        ram_en_d    = RAM_EN;
        ram_rw_d    = RAM_RW;
        ram_addr_d  = RAM_ADDR;
        ram_wdata_d = RAM_WDATA;

        case (state)
            IDLE: begin
                if (MFA) begin
                    state_d     = ACCESS;
                    byte_idx_d  = 2'd0;
                    wait_cnt_d  = '0;
                    byte_last_d = (SIZE == 2'b00) ? 2'd0 : (SIZE == 2'b01) ? 2'd1 : 2'd3;
                    rw_q_d      = RW;
                    rsh_d       = '0;
                    wsh_d       = {din_aligned[23:0], 8'h00};
                    ram_en_d    = 1'b1;
                    ram_rw_d    = RW;
                    ram_addr_d  = ADDR;
                    ram_wdata_d = din_aligned[31:24];
                end
            end
            ACCESS: begin
                if (!MFA) begin
                    state_d  = IDLE;
                    ram_en_d = 1'b0;
                end else if (wait_cnt == WAIT_LAST) begin
                    rsh_d      = rsh_next;
                    wait_cnt_d = '0;
                    if (byte_idx == byte_last) begin
                        state_d  = DONE;
                        ram_en_d = 1'b0;
                        if (rw_q) begin
                            dout_d = rsh_next;
                        end
                    end else begin
                        byte_idx_d  = byte_idx + 2'd1;
                        ram_addr_d  = RAM_ADDR + 8'd1;
                        ram_wdata_d = wsh[31:24];
                        wsh_d       = {wsh[23:0], 8'h00};
                    end
                end else begin
                    wait_cnt_d = wait_cnt + 4'd1;
                end
            end
            DONE: begin
                if (!MFA) begin
                    state_d = IDLE;
                    moc_d   = 1'b0;
                end else begin
                    moc_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                moc_d    = 1'b0;
                ram_en_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= IDLE;
            byte_idx  <= 2'd0;
            byte_last <= 2'd0;
            wait_cnt  <= '0;
            rw_q      <= 1'b1;
            wsh       <= '0;
            rsh       <= '0;
            DOUT      <= '0;
            MOC       <= 1'b0;
            RAM_EN    <= 1'b0;
            RAM_RW    <= 1'b1;
            RAM_ADDR  <= 8'h00;
            RAM_WDATA <= 8'h00;
        end else begin
            state     <= state_d;
            byte_idx  <= byte_idx_d;
            byte_last <= byte_last_d;
            wait_cnt  <= wait_cnt_d;
            rw_q      <= rw_q_d;
            wsh       <= wsh_d;
            rsh       <= rsh_d;
            DOUT      <= dout_d;
            MOC       <= moc_d;
            RAM_EN    <= ram_en_d;
            RAM_RW    <= ram_rw_d;
            RAM_ADDR  <= ram_addr_d;
            RAM_WDATA <= ram_wdata_d;
        end
    end

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Directed bench for ram_access_sequencer: one instance with 1 wait cycle per byte,
// one with 3, each attached to its own behavioural 256x8 RAM.
module tb_ram_access_sequencer;

    logic        clk;
    logic        rst_n;
    logic        mfa       [2];
    logic        rw        [2];
    logic [1:0]  size      [2];
    logic [7:0]  addr      [2];
    logic [31:0] din       [2];
    logic [31:0] dout      [2];
    logic        moc       [2];
    logic        ram_en    [2];
    logic        ram_rw    [2];
    logic [7:0]  ram_addr  [2];
    logic [7:0]  ram_wdata [2];
    logic [7:0]  ram_rdata [2];
    logic [7:0]  mem       [2][256];

    int vectors;
    int errors;

    ram_access_sequencer #(.WAIT_CYCLES(1)) dut0 (
        .CLK(clk), .nRESET(rst_n), .MFA(mfa[0]), .RW(rw[0]), .SIZE(size[0]),
        .ADDR(addr[0]), .DIN(din[0]), .DOUT(dout[0]), .MOC(moc[0]),
        .RAM_EN(ram_en[0]), .RAM_RW(ram_rw[0]), .RAM_ADDR(ram_addr[0]),
        .RAM_WDATA(ram_wdata[0]), .RAM_RDATA(ram_rdata[0])
    );

    ram_access_sequencer #(.WAIT_CYCLES(3)) dut1 (
        .CLK(clk), .nRESET(rst_n), .MFA(mfa[1]), .RW(rw[1]), .SIZE(size[1]),
        .ADDR(addr[1]), .DIN(din[1]), .DOUT(dout[1]), .MOC(moc[1]),
        .RAM_EN(ram_en[1]), .RAM_RW(ram_rw[1]), .RAM_ADDR(ram_addr[1]),
        .RAM_WDATA(ram_wdata[1]), .RAM_RDATA(ram_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAMs: combinational read, write on the rising edge while enabled
    assign ram_rdata[0] = ram_en[0] ? mem[0][ram_addr[0]] : 8'h00;
    assign ram_rdata[1] = ram_en[1] ? mem[1][ram_addr[1]] : 8'h00;

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (ram_en[u] && !ram_rw[u]) mem[u][ram_addr[u]] = ram_wdata[u];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full request with MFA handshake; checks addresses, write bytes, MOC edge and RAM_EN length
    task automatic do_req(input int u, input logic r, input logic [1:0] sz,
                          input logic [7:0] a, input logic [31:0] d, input int hold);
        int          w, n, en_cnt, moc_edge, k;
        logic [7:0]  ea;
        logic [31:0] t;
        w = (u == 0) ? 1 : 3;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        @(negedge clk);
        mfa[u] = 1'b1; rw[u] = r; size[u] = sz; addr[u] = a; din[u] = d;
        en_cnt = 0;
        moc_edge = -1;
        for (int e = 0; e <= 100 && moc_edge < 0; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin
                rw[u] = ~r; size[u] = ~sz; addr[u] = ~a; din[u] = ~d;
            end
            if (ram_en[u]) begin
                k  = en_cnt / w;
                ea = a + 8'(k);
                check("ram_addr", 32'(ram_addr[u]), 32'(ea));
                check("ram_rw", 32'(ram_rw[u]), 32'(r));
                if (!r) begin
                    t = d >> (8 * (n - 1 - k));
                    check("ram_wdata", 32'(ram_wdata[u]), 32'(t[7:0]));
                end
                en_cnt++;
            end
            if (moc[u]) moc_edge = e;
        end
        check("moc_edge", 32'(moc_edge), 32'(n * w + 1));
        check("en_cycles", 32'(en_cnt), 32'(n * w));
        repeat (hold) begin
            @(posedge clk); #1;
            check("moc_hold", 32'(moc[u]), 32'd1);
        end
        @(negedge clk);
        mfa[u] = 1'b0;
        @(posedge clk); #1;
        check("moc_release", 32'(moc[u]), 32'd0);
        check("ram_en_idle", 32'(ram_en[u]), 32'd0);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        for (int u = 0; u < 2; u++) begin
            mfa[u] = 1'b0; rw[u] = 1'b1; size[u] = 2'b00; addr[u] = 8'h00; din[u] = 32'h0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_moc", 32'(moc[0]), 32'd0);
        check("rst_ram_en", 32'(ram_en[0]), 32'd0);
        check("rst_ram_rw", 32'(ram_rw[0]), 32'd1);
        check("rst_ram_addr", 32'(ram_addr[0]), 32'h0);
        check("rst_ram_wdata", 32'(ram_wdata[0]), 32'h0);
        check("rst_dout", dout[0], 32'h0);
        check("rst_ram_rw_w3", 32'(ram_rw[1]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Word write then word read
        do_req(0, 1'b0, 2'b10, 8'h10, 32'hDEADBEEF, 0);
        check("wr_mem10", 32'(mem[0][8'h10]), 32'hDE);
        check("wr_mem11", 32'(mem[0][8'h11]), 32'hAD);
        check("wr_mem12", 32'(mem[0][8'h12]), 32'hBE);
        check("wr_mem13", 32'(mem[0][8'h13]), 32'hEF);
        check("wr_dout_kept", dout[0], 32'h0);
        do_req(0, 1'b1, 2'b10, 8'h10, 32'h0, 0);
        check("rd_word", dout[0], 32'hDEADBEEF);

        // Byte write (upper DIN bits ignored) and byte read
        do_req(0, 1'b0, 2'b00, 8'h20, 32'hFFFFFF9C, 0);
        check("wr_mem20", 32'(mem[0][8'h20]), 32'h9C);
        do_req(0, 1'b1, 2'b00, 8'h20, 32'h0, 0);
        check("rd_byte", dout[0], 32'h0000009C);

        // Halfword wrapping past 0xFF
        do_req(0, 1'b0, 2'b01, 8'hFF, 32'h00001234, 0);
        check("hw_dout_kept", dout[0], 32'h0000009C);
        check("wr_memff", 32'(mem[0][8'hFF]), 32'h12);
        check("wr_mem00", 32'(mem[0][8'h00]), 32'h34);
        do_req(0, 1'b1, 2'b01, 8'hFF, 32'h0, 0);
        check("rd_half_wrap", dout[0], 32'h00001234);

        // SIZE=11 behaves as a word
        do_req(0, 1'b1, 2'b11, 8'h10, 32'h0, 1);
        check("rd_size11", dout[0], 32'hDEADBEEF);

        // Abort a word write after its second byte
        do_req(0, 1'b0, 2'b10, 8'h40, 32'hAAAAAAAA, 0);
        @(negedge clk);
        mfa[0] = 1'b1; rw[0] = 1'b0; size[0] = 2'b10; addr[0] = 8'h40; din[0] = 32'h11223344;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        mfa[0] = 1'b0;
        @(posedge clk); #1;
        check("abort_ram_en", 32'(ram_en[0]), 32'd0);
        check("abort_moc", 32'(moc[0]), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_moc_low", 32'(moc[0]), 32'd0);
            check("abort_en_low", 32'(ram_en[0]), 32'd0);
        end
        check("abort_mem40", 32'(mem[0][8'h40]), 32'h11);
        check("abort_mem41", 32'(mem[0][8'h41]), 32'h22);
        check("abort_mem42", 32'(mem[0][8'h42]), 32'hAA);
        check("abort_mem43", 32'(mem[0][8'h43]), 32'hAA);
        check("abort_dout", dout[0], 32'hDEADBEEF);
        do_req(0, 1'b1, 2'b00, 8'h41, 32'h0, 0);
        check("post_abort_rd", dout[0], 32'h00000022);

        // Three wait cycles per byte, MOC held for 5 extra cycles
        do_req(1, 1'b0, 2'b10, 8'h80, 32'hA1B2C3D4, 0);
        do_req(1, 1'b1, 2'b10, 8'h80, 32'h0, 5);
        check("rd_word_w3", dout[1], 32'hA1B2C3D4);

        // Asynchronous reset in the middle of a word read
        @(negedge clk);
        mfa[0] = 1'b1; rw[0] = 1'b1; size[0] = 2'b10; addr[0] = 8'h10;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_moc", 32'(moc[0]), 32'd0);
        check("mid_rst_ram_en", 32'(ram_en[0]), 32'd0);
        check("mid_rst_dout", dout[0], 32'h0);
        check("mid_rst_ram_rw", 32'(ram_rw[0]), 32'd1);
        mfa[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_req(0, 1'b1, 2'b00, 8'h20, 32'h0, 0);
        check("post_rst_rd", dout[0], 32'h0000009C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ram_access_sequencer.md
# ram_access_sequencer

Sequences CPU memory requests onto the byte-wide 256x8 RAM. The control unit raises MFA with an address, direction and data size. The block expands the request into 1, 2 or 4 byte accesses with programmable wait states, assembles read data, and returns MOC. MOC is held until the control unit drops MFA. It sits between the control unit / MAR / MDR and the RAM, and replaces ad-hoc MOC timing with a single sequencer.

## Interface
- WAIT_CYCLES, 1: clock cycles per byte access, legal range 1..15
- CLK  input  1  system clock; all state changes on rising edge
- nRESET  input  1  reset, asynchronous, active-low
- MFA  input  1  memory function activate from control unit
- RW  input  1  1 = read, 0 = write
- SIZE  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
- ADDR  input  8  start byte address from MAR
- DIN  input  32  write data from MDR
- DOUT  output  32  assembled read data to MDR
- MOC  output  1  memory operation complete
- RAM_EN  output  1  RAM enable for current byte
- RAM_RW  output  1  RAM direction; 1 read, 0 write
- RAM_ADDR  output  8  RAM byte address
- RAM_WDATA  output  8  byte to write
- RAM_RDATA  input  8  byte read; combinational from RAM while RAM_EN=1

## Operation
- States: IDLE, ACCESS, DONE.
- Reset values: state IDLE, MOC 0, RAM_EN 0, RAM_RW 1, RAM_ADDR 0x00, RAM_WDATA 0x00, DOUT 0x00000000, byte and wait counters 0.
- **IDLE:** on an edge with MFA=1, latch ADDR, RW, SIZE and DIN, then enter ACCESS with byte index 0.
  - Set N = 1/2/4 from SIZE.
  - RAM_EN=1, RAM_ADDR=ADDR, RAM_RW=RW.
- **ACCESS:** each byte occupies exactly WAIT_CYCLES cycles.
  - RAM_ADDR, RAM_RW and RAM_WDATA stay stable for the whole window.
  - Byte k uses RAM_ADDR = ADDR+k mod 256; the address wraps from 0xFF to 0x00.
  - On the last edge of byte k's window, a read captures RAM_RDATA into byte slot k.
  - After byte k (k < N-1), advance to k+1 with no idle gap; RAM_EN stays 1.
  - After byte N-1, enter DONE.
- **Byte order (big-endian), writes:**
  - word: ADDR gets DIN[31:24], ADDR+1 gets DIN[23:16], ADDR+2 gets DIN[15:8], ADDR+3 gets DIN[7:0].
  - halfword: ADDR gets DIN[15:8], ADDR+1 gets DIN[7:0].
  - byte: ADDR gets DIN[7:0].
- **Byte order, reads:**
  - word, halfword and byte fill DOUT in the same byte positions as writes.
  - Unused upper bits of DOUT are zero-extended.
- **DOUT update:** DOUT changes only on entry to DONE after a read, and holds its value otherwise. Writes never change DOUT.
- **DONE:** MOC=1, RAM_EN=0.
  - Stay in DONE while MFA=1.
  - MFA=0 returns to IDLE and clears MOC on that edge.
- **Abort:** MFA=0 during ACCESS returns to IDLE on the next edge, with RAM_EN=0 and MOC never asserted.
  - Bytes already written stay written.
  - DOUT is not updated.
- **Asynchronous reset:** nRESET low at any time forces reset values immediately, including mid-ACCESS. A partial write is not rolled back.
- No alignment check. Unaligned halfword and word accesses are legal and wrap.

## Timing
- Edge 0 is the edge with MFA sampled high in IDLE.
- RAM_EN rises after edge 0.
- MOC rises after edge N*WAIT_CYCLES+1. Examples:
  - byte with WAIT_CYCLES=1: edge 2.
  - word with WAIT_CYCLES=1: edge 5.
  - word with WAIT_CYCLES=3: edge 13.
- RAM_EN is high for exactly N*WAIT_CYCLES consecutive cycles per completed request.
- MOC falls on the first edge with MFA=0 in DONE.
- A new request needs MFA low for at least one edge. With back-to-back requests, MFA=1 is resampled in IDLE, giving a minimum of one IDLE cycle between requests.
- MFA, RW, SIZE, ADDR and DIN are sampled only at edge 0. Changes to RW, SIZE, ADDR or DIN during ACCESS are ignored. MFA is also sampled every cycle in ACCESS and DONE, for abort and MOC release.

## Test plan
- **Word write then word read, WAIT_CYCLES=1:** write DIN=0xDEADBEEF to ADDR=0x10, then read ADDR=0x10.
  - Write: RAM gets 0xDE, 0xAD, 0xBE, 0xEF at 0x10..0x13; MOC rises at edge 5.
  - Read: DOUT=0xDEADBEEF.
- **Byte read:** RAM[0x20]=0x9C, SIZE=00, RW=1 -> DOUT=0x0000009C, MOC at edge 2, RAM_EN high 1 cycle.
- **Halfword wrap:** write DIN=0x00001234 to ADDR=0xFF -> RAM[0xFF]=0x12, RAM[0x00]=0x34; reading it back gives DOUT=0x00001234.
- **Wait states and handshake, WAIT_CYCLES=3, word read:**
  - RAM_EN high 12 cycles, each address held 3 cycles, MOC at edge 13.
  - MOC stays 1 while MFA is held 5 extra cycles, then falls on the first edge with MFA=0.
- **Abort:** drop MFA after byte 1 of a word write to 0x40 -> only 0x40 and 0x41 written, MOC stays 0, RAM_EN low next edge, state IDLE.
- **Reset mid-ACCESS:** assert nRESET low between edges -> MOC, RAM_EN 0 and DOUT 0 immediately. A new byte read after release completes normally.
